// File: rtl/fib_scan_ctrl.sv
// Sequencer that steps a shared 4-bit Fibonacci-digit detector through [lo..hi],
// collecting a hit count and per-value hit mask. Optional macro: FIB_SCAN_ERR_EN.
module fib_scan_ctrl #(
    parameter int MAXV  = 9,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       lo,
    input  logic [3:0]       hi,
    output logic [3:0]       det_in,
    input  logic             det_isfib,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [15:0]      hit_mask
`ifdef FIB_SCAN_ERR_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] MAXV_C = 4'(MAXV);

    state_t           state_q, state_d;
    logic [3:0]       hi_q, hi_d;
    logic [3:0]       det_in_q, det_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [15:0]      hit_mask_q, hit_mask_d;
    logic             err_q, err_d;
    logic [3:0]       hi_eff;

    // NOTE: every _d gets a default first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        det_in_d   = det_in_q;
        busy_d     = busy_q;
        done_d     = done_q;
        hit_cnt_d  = hit_cnt_q;
        hit_mask_d = hit_mask_q;
        err_d      = err_q;
`ifdef FIB_SCAN_ERR_EN
        hi_eff     = hi;
`else
        hi_eff     = (hi > MAXV_C) ? MAXV_C : hi;
`endif

        case (state_q)
            IDLE: begin
                busy_d   = 1'b0;
                done_d   = 1'b0;
                det_in_d = 4'd0;
                if (start) begin
                    hi_d       = hi_eff;
                    hit_cnt_d  = '0;
                    hit_mask_d = '0;
                    busy_d     = 1'b1;
`ifdef FIB_SCAN_ERR_EN
                    err_d      = (lo > MAXV_C);
`else
                    err_d      = 1'b0;
`endif
                    // Without the macro hi_eff <= MAXV, so lo > MAXV also lands here.
                    if (lo > hi_eff) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = SCAN;
                        det_in_d = lo;
                    end
                end
            end

            SCAN: begin
                if (det_isfib && (det_in_q <= MAXV_C)) begin
                    hit_cnt_d            = hit_cnt_q + CNT_W'(1);
                    hit_mask_d[det_in_q] = 1'b1;
                end
`ifdef FIB_SCAN_ERR_EN
                if (det_in_q > MAXV_C) begin
                    err_d = 1'b1;
                end
`endif
                if (det_in_q == hi_q) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    det_in_d = 4'd0;
                end else begin
                    det_in_d = det_in_q + 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end

            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                done_d   = 1'b0;
                det_in_d = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hi_q       <= 4'd0;
            det_in_q   <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_cnt_q  <= '0;
            hit_mask_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            det_in_q   <= det_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hit_cnt_q  <= hit_cnt_d;
            hit_mask_q <= hit_mask_d;
            err_q      <= err_d;
        end
    end

    assign det_in   = det_in_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hit_cnt  = hit_cnt_q;
    assign hit_mask = hit_mask_q;
`ifdef FIB_SCAN_ERR_EN
    assign err      = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_fib_scan_ctrl.sv
// Directed self-checking bench for fib_scan_ctrl; honours FIB_SCAN_ERR_EN like the RTL.
module tb_fib_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  lo = 4'd0;
    logic [3:0]  hi = 4'd0;
    logic [3:0]  det_in;
    logic        det_isfib;
    logic        busy;
    logic        done;
    logic [4:0]  hit_cnt;
    logic [15:0] hit_mask;
`ifdef FIB_SCAN_ERR_EN
    logic        err;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Codes above 9 read as hits so any counting of illegal codes shows up.
    assign det_isfib = (det_in > 4'd9) ? 1'b1 : (det_in inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8});

    fib_scan_ctrl #(.MAXV(9), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lo        (lo),
        .hi        (hi),
        .det_in    (det_in),
        .det_isfib (det_isfib),
        .busy      (busy),
        .done      (done),
        .hit_cnt   (hit_cnt),
        .hit_mask  (hit_mask)
`ifdef FIB_SCAN_ERR_EN
        ,
        .err       (err)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n == 0 means an empty range: done directly after accept.
    task automatic run_scan(input string tag, input logic [3:0] l, input logic [3:0] h,
                            input int first, input int n, input int cnt,
                            input logic [15:0] mask, input logic e, input bit hammer);
        start = 1'b1;
        lo    = l;
        hi    = h;
        step();
        if (hammer) begin
            lo = 4'd3;
            hi = 4'd3;
        end else begin
            start = 1'b0;
            lo    = 4'd15;
            hi    = 4'd0;
        end
        for (int k = 0; k < n; k++) begin
            chk({tag, ":scan_busy"}, 32'(busy), 32'd1);
            chk({tag, ":scan_det_in"}, 32'(det_in), 32'(first + k));
            chk({tag, ":scan_done"}, 32'(done), 32'd0);
            step();
        end
        chk({tag, ":done"}, 32'(done), 32'd1);
        chk({tag, ":done_busy"}, 32'(busy), 32'd1);
        chk({tag, ":done_det_in"}, 32'(det_in), 32'd0);
        chk({tag, ":hit_cnt"}, 32'(hit_cnt), 32'(cnt));
        chk({tag, ":hit_mask"}, 32'(hit_mask), 32'(mask));
`ifdef FIB_SCAN_ERR_EN
        chk({tag, ":err"}, 32'(err), 32'(e));
`else
        if (e) $display("note: %s expects err but the port is absent in this build", tag);
`endif
        step();
        start = 1'b0;
        chk({tag, ":after_done"}, 32'(done), 32'd0);
        chk({tag, ":after_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen_done;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:det_in", 32'(det_in), 32'd0);
        chk("rst:hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst:hit_mask", 32'(hit_mask), 32'd0);
`ifdef FIB_SCAN_ERR_EN
        chk("rst:err", 32'(err), 32'd0);
`endif
        rst = 1'b0;
        step();

        // 1: full legal range
        run_scan("t1", 4'd0, 4'd9, 0, 10, 6, 16'h012F, 1'b0, 1'b0);
        step();
        step();
        chk("t1:hold_cnt", 32'(hit_cnt), 32'd6);
        chk("t1:hold_mask", 32'(hit_mask), 32'h012F);
        chk("t1:idle_det_in", 32'(det_in), 32'd0);

        // 2: single-value ranges, miss then hit
        run_scan("t2a", 4'd4, 4'd4, 4, 1, 0, 16'h0000, 1'b0, 1'b0);
        run_scan("t2b", 4'd8, 4'd8, 8, 1, 1, 16'h0100, 1'b0, 1'b0);

        // 3: empty range
        run_scan("t3", 4'd7, 4'd3, 0, 0, 0, 16'h0000, 1'b0, 1'b0);

        // 4: range crossing MAXV
`ifdef FIB_SCAN_ERR_EN
        run_scan("t4", 4'd6, 4'd15, 6, 10, 1, 16'h0100, 1'b1, 1'b0);
        run_scan("t4b", 4'd12, 4'd14, 12, 3, 0, 16'h0000, 1'b1, 1'b0);
`else
        run_scan("t4", 4'd6, 4'd15, 6, 4, 1, 16'h0100, 1'b0, 1'b0);
        run_scan("t4b", 4'd12, 4'd14, 0, 0, 0, 16'h0000, 1'b0, 1'b0);
`endif

        // 5: start held through every busy cycle, then back-to-back start after done
        run_scan("t5a", 4'd0, 4'd9, 0, 10, 6, 16'h012F, 1'b0, 1'b1);
        run_scan("t5b", 4'd0, 4'd2, 0, 3, 3, 16'h0007, 1'b0, 1'b0);

        // 6: reset on the third scan cycle
        start = 1'b1;
        lo    = 4'd0;
        hi    = 4'd9;
        step();
        start = 1'b0;
        step();
        step();
        chk("t6:third_det_in", 32'(det_in), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6:busy", 32'(busy), 32'd0);
        chk("t6:done", 32'(done), 32'd0);
        chk("t6:hit_cnt", 32'(hit_cnt), 32'd0);
        chk("t6:hit_mask", 32'(hit_mask), 32'd0);
        chk("t6:det_in", 32'(det_in), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (done || busy) seen_done = 1'b1;
            step();
        end
        chk("t6:no_done_after_rst", 32'(seen_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
